// File: rtl/ram_access_ctrl.sv
// CPU-side initiator for the 4-bit data RAM: holds the DCL bank and SRC address
// registers and turns WRM/RDM/WRS/RDS/ADM/SBM commands into single RAM cycles.
module ram_access_ctrl #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        dcl_we,
    input  logic [2:0]  dcl_data,
    input  logic        src_we,
    input  logic [7:0]  src_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_idx,
    input  logic [3:0]  cmd_acc,
    input  logic        cmd_cy,
    output logic        rsp_valid,
    output logic [3:0]  rsp_data,
    output logic        rsp_cy,
    output logic        ramWe,
    output logic        ramRe,
    output logic [11:0] ramAddr,
    output logic [3:0]  ramDataOut,
    input  logic [3:0]  ramDataIn
);

    localparam logic [2:0] OP_WRM = 3'd0;
    localparam logic [2:0] OP_RDM = 3'd1;
    localparam logic [2:0] OP_WRS = 3'd2;
    localparam logic [2:0] OP_RDS = 3'd3;
    localparam logic [2:0] OP_ADM = 3'd4;
    localparam logic [2:0] OP_SBM = 3'd5;

    // Extra wait cycles after the strobe cycle, counted down to zero.
    localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  dcl_q, dcl_d;
    logic [7:0]  src_q, src_d;
    logic [2:0]  op_q, op_d;
    logic [3:0]  acc_q, acc_d;
    logic        cy_q, cy_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic        ram_we_q, ram_we_d;
    logic        ram_re_q, ram_re_d;
    logic [11:0] ram_addr_q, ram_addr_d;
    logic [3:0]  ram_dout_q, ram_dout_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [3:0]  rsp_data_q, rsp_data_d;
    logic        rsp_cy_q, rsp_cy_d;

    logic        is_write;
    logic        is_read;
    logic        is_status;
    logic [11:0] cmd_addr;
    logic        capture;
    logic [4:0]  sum_add;
    logic [4:0]  sum_sub;

    always_comb begin
        is_write  = (cmd_op == OP_WRM) || (cmd_op == OP_WRS);
        is_read   = (cmd_op == OP_RDM) || (cmd_op == OP_RDS) ||
                    (cmd_op == OP_ADM) || (cmd_op == OP_SBM);
        is_status = (cmd_op == OP_WRS) || (cmd_op == OP_RDS);
        // Address uses the registered DCL/SRC, so a same-edge load is not seen.
        if (is_status) begin
            cmd_addr = {1'b1, dcl_q, src_q[7:4], 2'b00, cmd_idx};
        end else begin
            cmd_addr = {1'b0, dcl_q, src_q};
        end
    end

    always_comb begin
        capture = ((state_q == S_READ) && (RD_LAT == 1)) ||
                  ((state_q == S_WAIT) && (wait_cnt_q == 2'd0));
        sum_add = {1'b0, acc_q} + {1'b0, ramDataIn} + {4'd0, cy_q};
        // cy=1 is a borrow-in, so the carry injected is its complement.
        sum_sub = {1'b0, acc_q} + {1'b0, ~ramDataIn} + {4'd0, ~cy_q};
    end

    always_comb begin
        state_d     = state_q;
        dcl_d       = dcl_we ? dcl_data : dcl_q;
        src_d       = src_we ? src_data : src_q;
        op_d        = op_q;
        acc_d       = acc_q;
        cy_d        = cy_q;
        wait_cnt_d  = wait_cnt_q;
        ram_we_d    = 1'b0;
        ram_re_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_dout_d  = ram_dout_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_cy_d    = rsp_cy_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    acc_d = cmd_acc;
                    cy_d  = cmd_cy;
                    if (is_write) begin
                        state_d    = S_WRITE;
                        ram_we_d   = 1'b1;
                        ram_addr_d = cmd_addr;
                        ram_dout_d = cmd_acc;
                    end else if (is_read) begin
                        state_d    = S_READ;
                        ram_re_d   = 1'b1;
                        ram_addr_d = cmd_addr;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = cmd_acc;
                        rsp_cy_d    = cmd_cy;
                    end
                end
            end
            S_WRITE: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = acc_q;
                rsp_cy_d    = cy_q;
            end
            S_READ: begin
                if (!capture) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = WAIT_INIT;
                end
            end
            S_WAIT: begin
                if (!capture) begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture) begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b1;
            case (op_q)
                OP_ADM: begin
                    rsp_data_d = sum_add[3:0];
                    rsp_cy_d   = sum_add[4];
                end
                OP_SBM: begin
                    rsp_data_d = sum_sub[3:0];
                    rsp_cy_d   = sum_sub[4];
                end
                default: begin
                    rsp_data_d = ramDataIn;
                    rsp_cy_d   = cy_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q     <= S_IDLE;
            dcl_q       <= 3'd0;
            src_q       <= 8'd0;
            op_q        <= 3'd0;
            acc_q       <= 4'd0;
            cy_q        <= 1'b0;
            wait_cnt_q  <= 2'd0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= 12'd0;
            ram_dout_q  <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 4'd0;
            rsp_cy_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcl_q       <= dcl_d;
            src_q       <= src_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            cy_q        <= cy_d;
            wait_cnt_q  <= wait_cnt_d;
            ram_we_q    <= ram_we_d;
            ram_re_q    <= ram_re_d;
            ram_addr_q  <= ram_addr_d;
            ram_dout_q  <= ram_dout_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_cy_q    <= rsp_cy_d;
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_cy     = rsp_cy_q;
    assign ramWe      = ram_we_q;
    assign ramRe      = ram_re_q;
    assign ramAddr    = ram_addr_q;
    assign ramDataOut = ram_dout_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: one instance at RD_LAT=1, one at RD_LAT=3,
// each with its own behavioural RAM that presents data only in the legal cycle.
module tb_ram_access_ctrl;

    localparam logic [2:0] OP_WRM = 3'd0;
    localparam logic [2:0] OP_RDM = 3'd1;
    localparam logic [2:0] OP_WRS = 3'd2;
    localparam logic [2:0] OP_RDS = 3'd3;
    localparam logic [2:0] OP_ADM = 3'd4;
    localparam logic [2:0] OP_SBM = 3'd5;
    localparam logic [2:0] OP_NOP = 3'd7;

    logic        clk = 1'b0;
    logic        rstN;
    logic        dcl_we, src_we;
    logic [2:0]  dcl_data;
    logic [7:0]  src_data;
    logic        cmd_valid1, cmd_valid3;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_idx;
    logic [3:0]  cmd_acc;
    logic        cmd_cy;

    logic        ready1, rsp_valid1, rsp_cy1, we1, re1;
    logic [3:0]  rsp_data1, dout1, din1;
    logic [11:0] addr1;
    logic        ready3, rsp_valid3, rsp_cy3, we3, re3;
    logic [3:0]  rsp_data3, dout3, din3;
    logic [11:0] addr3;

    logic [3:0]  mem1 [4096];
    logic [3:0]  mem3 [4096];
    int          age3;

    int n_checks = 0;
    int n_pass   = 0;

    logic        sel;
    logic        m_ready, m_rsp_valid, m_rsp_cy, m_we, m_re;
    logic [3:0]  m_rsp_data, m_dout;
    logic [11:0] m_addr;

    int          r_we_at, r_we_cnt, r_re_at, r_re_cnt, r_rsp_at, r_rsp_cnt;
    logic [11:0] r_addr;
    logic [3:0]  r_wdata, r_data;
    logic        r_cy, r_ready_rsp;

    logic        acc_src_en = 1'b0;
    logic [7:0]  acc_src_val = 8'h00;
    int          mid_k = 0;
    logic [7:0]  mid_val = 8'h00;

    always #5 clk = ~clk;

    ram_access_ctrl #(.RD_LAT(1)) dut (
        .clk(clk), .rstN(rstN),
        .dcl_we(dcl_we), .dcl_data(dcl_data), .src_we(src_we), .src_data(src_data),
        .cmd_valid(cmd_valid1), .cmd_ready(ready1), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
        .cmd_acc(cmd_acc), .cmd_cy(cmd_cy),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_cy(rsp_cy1),
        .ramWe(we1), .ramRe(re1), .ramAddr(addr1), .ramDataOut(dout1), .ramDataIn(din1)
    );

    ram_access_ctrl #(.RD_LAT(3)) dut3 (
        .clk(clk), .rstN(rstN),
        .dcl_we(dcl_we), .dcl_data(dcl_data), .src_we(src_we), .src_data(src_data),
        .cmd_valid(cmd_valid3), .cmd_ready(ready3), .cmd_op(cmd_op), .cmd_idx(cmd_idx),
        .cmd_acc(cmd_acc), .cmd_cy(cmd_cy),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_cy(rsp_cy3),
        .ramWe(we3), .ramRe(re3), .ramAddr(addr3), .ramDataOut(dout3), .ramDataIn(din3)
    );

    // RAM models: correct data only in the capture cycle, inverted data otherwise.
    always @(posedge clk) begin
        if (we1) mem1[addr1] <= dout1;
        if (we3) mem3[addr3] <= dout3;
        if (!rstN)                      age3 <= 0;
        else if (re3)                   age3 <= 1;
        else if (age3 != 0 && age3 < 3) age3 <= age3 + 1;
        else                            age3 <= 0;
    end

    always_comb begin
        din1 = re1 ? mem1[addr1] : ~mem1[addr1];
        din3 = (age3 == 2) ? mem3[addr3] : ~mem3[addr3];
    end

    always_comb begin
        m_ready     = sel ? ready3 : ready1;
        m_rsp_valid = sel ? rsp_valid3 : rsp_valid1;
        m_rsp_data  = sel ? rsp_data3 : rsp_data1;
        m_rsp_cy    = sel ? rsp_cy3 : rsp_cy1;
        m_we        = sel ? we3 : we1;
        m_re        = sel ? re3 : re1;
        m_addr      = sel ? addr3 : addr1;
        m_dout      = sel ? dout3 : dout1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic load_regs(input logic [2:0] d, input logic [7:0] s);
        @(negedge clk);
        dcl_we = 1'b1; dcl_data = d; src_we = 1'b1; src_data = s;
        @(negedge clk);
        dcl_we = 1'b0; src_we = 1'b0;
    endtask

    // Issue one command and record what happens in the 8 cycles after accept.
    task automatic exec(input logic use3, input logic [2:0] op, input logic [1:0] idx,
                        input logic [3:0] acc, input logic c);
        int waited;
        sel = use3;
        waited = 0;
        @(negedge clk);
        while (!m_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_cmd", {31'd0, m_ready}, 32'd1);
        cmd_op = op; cmd_idx = idx; cmd_acc = acc; cmd_cy = c;
        if (use3) cmd_valid3 = 1'b1; else cmd_valid1 = 1'b1;
        if (acc_src_en) begin src_we = 1'b1; src_data = acc_src_val; end
        r_we_at = -1; r_we_cnt = 0; r_re_at = -1; r_re_cnt = 0;
        r_rsp_at = -1; r_rsp_cnt = 0; r_addr = '0; r_wdata = '0;
        r_data = '0; r_cy = 1'b0; r_ready_rsp = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            cmd_valid1 = 1'b0; cmd_valid3 = 1'b0; src_we = 1'b0; acc_src_en = 1'b0;
            if (k == mid_k) begin src_we = 1'b1; src_data = mid_val; end
            if (m_we) begin
                r_we_cnt++;
                if (r_we_at < 0) begin r_we_at = k; r_addr = m_addr; r_wdata = m_dout; end
            end
            if (m_re) begin
                r_re_cnt++;
                if (r_re_at < 0) begin r_re_at = k; r_addr = m_addr; end
            end
            if (m_rsp_valid) begin
                r_rsp_cnt++;
                if (r_rsp_at < 0) begin
                    r_rsp_at = k; r_data = m_rsp_data; r_cy = m_rsp_cy; r_ready_rsp = m_ready;
                end
            end
        end
        mid_k = 0;
        $display("txn lat%0d op=%0d acc=%h cy=%0d -> addr=%h rsp_at=N+%0d data=%h cy=%0d",
                 use3 ? 3 : 1, op, acc, c, r_addr, r_rsp_at, r_data, r_cy);
    endtask

    task automatic check_txn(input string tag, input int we_cnt, input int re_cnt,
                             input logic [11:0] addr, input int at,
                             input logic [3:0] d, input logic c);
        check({tag, ".rsp_at"}, r_rsp_at, at);
        check({tag, ".rsp_cnt"}, r_rsp_cnt, 1);
        check({tag, ".data"}, {28'd0, r_data}, {28'd0, d});
        check({tag, ".cy"}, {31'd0, r_cy}, {31'd0, c});
        check({tag, ".we_cnt"}, r_we_cnt, we_cnt);
        check({tag, ".re_cnt"}, r_re_cnt, re_cnt);
        if (we_cnt + re_cnt > 0) begin
            check({tag, ".strobe_at"}, (we_cnt > 0) ? r_we_at : r_re_at, 1);
            check({tag, ".addr"}, {20'd0, r_addr}, {20'd0, addr});
        end
        if (we_cnt > 0) check({tag, ".wdata"}, {28'd0, r_wdata}, {28'd0, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        rstN = 1'b0; dcl_we = 1'b0; src_we = 1'b0; dcl_data = '0; src_data = '0;
        cmd_valid1 = 1'b0; cmd_valid3 = 1'b0; cmd_op = '0; cmd_idx = '0;
        cmd_acc = '0; cmd_cy = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        check("rst.ready1", {31'd0, ready1}, 32'd1);
        check("rst.ready3", {31'd0, ready3}, 32'd1);
        check("rst.rsp_valid", {31'd0, rsp_valid1}, 32'd0);
        check("rst.strobes", {30'd0, we1, re1}, 32'd0);
        check("rst.addr", {20'd0, addr1}, 32'd0);
        check("rst.rsp", {27'd0, rsp_cy1, rsp_data1}, 32'd0);

        // Main-memory write and read back at both latencies.
        load_regs(3'd5, 8'hA7);
        exec(1'b0, OP_WRM, 2'd0, 4'h9, 1'b0);
        check_txn("wrm", 1, 0, 12'h5A7, 2, 4'h9, 1'b0);
        check("wrm.ready_at_rsp", {31'd0, r_ready_rsp}, 32'd1);
        exec(1'b0, OP_RDM, 2'd0, 4'h0, 1'b1);
        check_txn("rdm_lat1", 0, 1, 12'h5A7, 2, 4'h9, 1'b1);
        exec(1'b1, OP_WRM, 2'd0, 4'h9, 1'b0);
        check_txn("wrm_lat3", 1, 0, 12'h5A7, 2, 4'h9, 1'b0);
        exec(1'b1, OP_RDM, 2'd0, 4'h0, 1'b1);
        check_txn("rdm_lat3", 0, 1, 12'h5A7, 4, 4'h9, 1'b1);

        // Status characters: {1, DCL, chip, reg, 00, idx}.
        load_regs(3'd1, 8'h30);
        exec(1'b0, OP_WRS, 2'd2, 4'hC, 1'b0);
        check_txn("wrs", 1, 0, 12'h932, 2, 4'hC, 1'b0);
        exec(1'b0, OP_RDS, 2'd2, 4'h0, 1'b0);
        check_txn("rds", 0, 1, 12'h932, 2, 4'hC, 1'b0);

        // Arithmetic against memory at 12'h130.
        exec(1'b0, OP_WRM, 2'd0, 4'h7, 1'b0);
        check_txn("wrm7", 1, 0, 12'h130, 2, 4'h7, 1'b0);
        exec(1'b0, OP_ADM, 2'd0, 4'hB, 1'b1);
        check_txn("adm", 0, 1, 12'h130, 2, 4'h3, 1'b1);
        exec(1'b0, OP_WRM, 2'd0, 4'h3, 1'b0);
        exec(1'b0, OP_SBM, 2'd0, 4'h5, 1'b0);
        check_txn("sbm_cy0", 0, 1, 12'h130, 2, 4'h2, 1'b1);
        exec(1'b0, OP_SBM, 2'd0, 4'h5, 1'b1);
        check_txn("sbm_cy1", 0, 1, 12'h130, 2, 4'h1, 1'b1);
        exec(1'b1, OP_WRM, 2'd0, 4'h7, 1'b0);
        exec(1'b1, OP_ADM, 2'd0, 4'hB, 1'b1);
        check_txn("adm_lat3", 0, 1, 12'h130, 4, 4'h3, 1'b1);

        // SRC loads at accept and mid-read only affect later commands.
        load_regs(3'd1, 8'h45);
        exec(1'b0, OP_WRM, 2'd0, 4'hE, 1'b0);
        load_regs(3'd1, 8'h46);
        exec(1'b0, OP_WRM, 2'd0, 4'h1, 1'b0);
        load_regs(3'd1, 8'h30);
        acc_src_en = 1'b1; acc_src_val = 8'h45;
        exec(1'b0, OP_RDM, 2'd0, 4'h0, 1'b0);
        check_txn("src_at_accept", 0, 1, 12'h130, 2, 4'h3, 1'b0);
        mid_k = 1; mid_val = 8'h46;
        exec(1'b0, OP_RDM, 2'd0, 4'h0, 1'b0);
        check_txn("src_mid_read", 0, 1, 12'h145, 2, 4'hE, 1'b0);
        exec(1'b0, OP_RDM, 2'd0, 4'h0, 1'b0);
        check_txn("src_new", 0, 1, 12'h146, 2, 4'h1, 1'b0);

        // Reset while the RD_LAT=3 read waits.
        sel = 1'b1;
        @(negedge clk);
        cmd_op = OP_RDM; cmd_acc = 4'h0; cmd_cy = 1'b0; cmd_valid3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid3 = 1'b0;
        check("rst_mid.re_issued", {31'd0, re3}, 32'd1);
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        check("rst_mid.ramRe", {31'd0, re3}, 32'd0);
        check("rst_mid.ready", {31'd0, ready3}, 32'd1);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (rsp_valid3) seen++;
            @(negedge clk);
        end
        check("rst_mid.no_rsp", seen, 0);
        exec(1'b0, OP_WRM, 2'd0, 4'h6, 1'b0);
        check_txn("post_rst_addr", 1, 0, 12'h000, 2, 4'h6, 1'b0);

        // NOP: immediate response, no RAM activity, result held afterwards.
        exec(1'b0, OP_NOP, 2'd0, 4'hA, 1'b1);
        check_txn("nop", 0, 0, 12'h000, 1, 4'hA, 1'b1);
        check("nop.hold", {27'd0, rsp_cy1, rsp_data1}, {27'd0, 1'b1, 4'hA});
        check("nop.no_repeat", {31'd0, rsp_valid1}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
